// File: rtl/fifo_shift_delay_pkg.sv
// Shared constants and types for the shift-register delay line.
// Latency: n/a (declarations only).
// Backpressure: n/a; the delay line has no handshake.
package fifo_shift_delay_pkg;

   localparam int FIFO_WIDTH_DEFAULT = 8;
   localparam int FIFO_DEPTH_DEFAULT = 4;

   typedef logic [FIFO_WIDTH_DEFAULT-1:0] data_t;

endpackage : fifo_shift_delay_pkg

// File: rtl/fifo_shift_stage.sv
// One register stage of the delay line, with a synchronous active-low clear and a load enable.
// Latency: 1 enabled clock from d to q.
// Backpressure: none; en low holds the stored word. Ports: clk, clr_n, en, d -> q.
module fifo_shift_stage
   import fifo_shift_delay_pkg::*;
#(
   parameter int WIDTH = FIFO_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Clear has priority over the enable, so a reset mid-stream always empties the stage.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule : fifo_shift_stage

// File: rtl/fifo_shift_delay.sv
// Fixed-length shift-register delay line; OUT_W is the word pushed in DEPTH enabled edges earlier.
// Latency: DEPTH enabled CLK edges from SHIN to OUT_W; disabled edges do not count.
// Backpressure: none; EN low freezes every stage. Ports: CLK, aclr_n (sync, low), EN, SHIN -> OUT_W.
module fifo_shift_delay
   import fifo_shift_delay_pkg::*;
#(
   parameter int WIDTH = FIFO_WIDTH_DEFAULT,
   parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
   input  logic             CLK,
   input  logic             aclr_n,
   input  logic             EN,
   input  logic [WIDTH-1:0] SHIN,
   output logic [WIDTH-1:0] OUT_W
);

   if (DEPTH < 1 || WIDTH < 1) begin : g_bad_param
      $error("fifo_shift_delay: DEPTH and WIDTH must both be at least 1");
   end

   logic [WIDTH-1:0] stage_q [DEPTH];

   // Stage 0 takes SHIN, every later stage takes its predecessor; all share one enable
   // so the whole line advances or holds as a unit.
   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic [WIDTH-1:0] stage_d;

      if (i == 0) begin : g_head
         assign stage_d = SHIN;
      end else begin : g_link
         assign stage_d = stage_q[i-1];
      end

      fifo_shift_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk   (CLK),
         .clr_n (aclr_n),
         .en    (EN),
         .d     (stage_d),
         .q     (stage_q[i])
      );
   end

   // Straight from the last register: no combinational path from SHIN or EN.
   assign OUT_W = stage_q[DEPTH-1];

endmodule : fifo_shift_delay

// File: tb/tb_fifo_shift_delay.sv
// Scoreboard bench for fifo_shift_delay at DEPTH 4 (hand-computed), 1 and 8 (queue model).
// Latency: expectations are pushed at each rising edge and checked on the following falling edge.
// Backpressure: n/a; the monitor compares whenever an expectation is pending.
module tb_fifo_shift_delay;

   logic       CLK;
   logic       aclr_n;
   logic       EN;
   logic [7:0] SHIN;
   logic [7:0] out4, out1, out8;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string      name;
      logic [7:0] e4;
      logic [7:0] e1;
      logic [7:0] e8;
   } exp_t;

   exp_t       sb_q [$];
   logic [7:0] m1_q [$];
   logic [7:0] m8_q [$];

   fifo_shift_delay #(.WIDTH(8), .DEPTH(4)) u_dut4 (
      .CLK(CLK), .aclr_n(aclr_n), .EN(EN), .SHIN(SHIN), .OUT_W(out4));
   fifo_shift_delay #(.WIDTH(8), .DEPTH(1)) u_dut1 (
      .CLK(CLK), .aclr_n(aclr_n), .EN(EN), .SHIN(SHIN), .OUT_W(out1));
   fifo_shift_delay #(.WIDTH(8), .DEPTH(8)) u_dut8 (
      .CLK(CLK), .aclr_n(aclr_n), .EN(EN), .SHIN(SHIN), .OUT_W(out8));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference delay line: front of the queue is the oldest word, i.e. the output.
   task automatic model_reset();
      m1_q.delete();
      m8_q.delete();
      m1_q.push_back(8'h00);
      for (int i = 0; i < 8; i++) m8_q.push_back(8'h00);
   endtask

   task automatic model_shift(input logic [7:0] d);
      m1_q.push_back(d);
      void'(m1_q.pop_front());
      m8_q.push_back(d);
      void'(m8_q.pop_front());
   endtask

   // Apply one cycle of stimulus; e4 is the hand-computed DEPTH=4 output after this edge.
   task automatic step(input logic en, input logic rn, input logic [7:0] d,
                       input logic [7:0] e4, input string nm);
      exp_t e;
      EN     = en;
      aclr_n = rn;
      SHIN   = d;
      @(posedge CLK);
      if (!rn)     model_reset();
      else if (en) model_shift(d);
      e.name = nm;
      e.e4   = e4;
      e.e1   = m1_q[0];
      e.e8   = m8_q[0];
      sb_q.push_back(e);
      #1;
   endtask

   task automatic check(input string nm, input string tag,
                        input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s %s: got %h expected %h", nm, tag, got, exp);
      end
   endtask

   // Monitor: pops one expectation per falling edge and compares all three instances.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check(e.name, "depth4", out4, e.e4);
            check(e.name, "depth1", out1, e.e1);
            check(e.name, "depth8", out8, e.e8);
         end
      end
   end

   initial begin
      int waited;
      EN     = 1'b0;
      aclr_n = 1'b1;
      SHIN   = 8'h00;
      model_reset();

      // Reset held two edges with enable and all-ones data.
      step(1, 0, 8'hFF, 8'h00, "rst_a");
      step(1, 0, 8'hFF, 8'h00, "rst_b");
      // Three enabled edges: nothing has reached the last stage yet.
      step(1, 1, 8'h11, 8'h00, "fill_1");
      step(1, 1, 8'h22, 8'h00, "fill_2");
      step(1, 1, 8'h33, 8'h00, "fill_3");

      // Walking bit after a fresh reset.
      step(1, 0, 8'h00, 8'h00, "rst_walk");
      step(1, 1, 8'h01, 8'h00, "walk_1");
      step(1, 1, 8'h02, 8'h00, "walk_2");
      step(1, 1, 8'h04, 8'h00, "walk_4");
      step(1, 1, 8'h08, 8'h01, "walk_8");
      step(1, 1, 8'h10, 8'h02, "walk_16");
      step(1, 1, 8'h20, 8'h04, "walk_32");
      step(1, 1, 8'h00, 8'h08, "walk_flush1");
      step(1, 1, 8'h00, 8'h10, "walk_flush2");

      // Same stream with a one-cycle stall after the third word.
      step(1, 0, 8'h00, 8'h00, "rst_stall");
      step(1, 1, 8'h01, 8'h00, "stall_1");
      step(1, 1, 8'h02, 8'h00, "stall_2");
      step(1, 1, 8'h04, 8'h00, "stall_4");
      step(0, 1, 8'h99, 8'h00, "stall_hold");
      step(1, 1, 8'h08, 8'h01, "stall_8");
      step(1, 1, 8'h10, 8'h02, "stall_16");
      step(1, 1, 8'h20, 8'h04, "stall_32");
      step(1, 1, 8'h00, 8'h08, "stall_flush1");
      step(1, 1, 8'h00, 8'h10, "stall_flush2");
      step(1, 1, 8'h00, 8'h20, "stall_flush3");

      // Fill with A1..A4, then reset mid-stream with EN high (reset wins).
      step(1, 1, 8'hA1, 8'h00, "mid_a1");
      step(1, 1, 8'hA2, 8'h00, "mid_a2");
      step(1, 1, 8'hA3, 8'h00, "mid_a3");
      step(1, 1, 8'hA4, 8'hA1, "mid_a4");
      step(1, 0, 8'h55, 8'h00, "mid_rst_en");
      step(1, 1, 8'hB1, 8'h00, "post_b1");
      step(1, 1, 8'hB2, 8'h00, "post_b2");
      step(1, 1, 8'hB3, 8'h00, "post_b3");
      step(1, 1, 8'hB4, 8'hB1, "post_b4");
      // Hold ignores SHIN; DEPTH=1 instance shows 5A right after its enabled edge.
      step(0, 1, 8'hEE, 8'hB1, "hold_ign");
      step(1, 1, 8'h5A, 8'hB2, "d1_5a");
      step(0, 0, 8'h77, 8'h00, "rst_no_en");

      waited = 0;
      while (sb_q.size() != 0 && waited < 20) begin
         @(posedge CLK);
         waited++;
      end
      @(posedge CLK);
      if (sb_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expectations pending, expected 0", sb_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_fifo_shift_delay
